// File: rtl/program_load_sequencer.sv
// Program load sequencer: assembles 2-bit cartridge colors into program
// words, writes them to RAM, then hands the RAM read port to the CPU.
module program_load_sequencer #(
    parameter int WORD_BITS     = 12,
    parameter int ADDR_BITS     = 8,
    parameter int NITS_PER_WORD = 6,
    parameter int TIMEOUT       = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] load_len,
    input  logic                 color_ready,
    input  logic [1:0]           color,
    input  logic                 cpu_req,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    output logic                 cpu_grant,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_waddr,
    output logic [WORD_BITS-1:0] ram_wdata,
    output logic [ADDR_BITS-1:0] ram_raddr,
    output logic                 loading,
    output logic                 done,
    output logic                 error
);

    localparam int NIT_W = $clog2(NITS_PER_WORD + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] word_cnt, len_q, last_idx, wc_now;
    logic [NIT_W-1:0]     nit_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [WORD_BITS-1:0] shreg, shreg_next;
    logic                 accept_start, last_wr, timeout_hit, word_done;

    // load_len of 0 means a full 2^ADDR_BITS words, which the wrap gives for free
    assign last_idx     = len_q - ADDR_BITS'(1);
    assign accept_start = start && (state_q != LOAD);
    assign last_wr      = (state_q == LOAD) && ram_we && (ram_waddr == last_idx);
    assign timeout_hit  = (state_q == LOAD) && !color_ready && !last_wr &&
                          (to_cnt == TO_W'(TIMEOUT - 1));
    assign word_done    = (state_q == LOAD) && color_ready &&
                          (nit_cnt == NIT_W'(NITS_PER_WORD - 1));
    assign shreg_next   = {shreg[WORD_BITS-3:0], color};
    // address of the word being completed, accounting for an increment in flight
    assign wc_now       = ram_we ? word_cnt + ADDR_BITS'(1) : word_cnt;

    assign loading   = (state_q == LOAD);
    assign done      = (state_q == RUN);
    assign cpu_grant = cpu_req && (state_q == RUN);
    assign ram_raddr = (state_q == RUN) ? cpu_addr : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD: begin
                if (last_wr)          state_d = RUN;
                else if (timeout_hit) state_d = IDLE;
            end
            RUN:     if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Word assembly, counters, RAM write port and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt  <= '0;
            len_q     <= '0;
            nit_cnt   <= '0;
            to_cnt    <= '0;
            shreg     <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            error     <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (accept_start) begin
                word_cnt <= '0;
                nit_cnt  <= '0;
                to_cnt   <= '0;
                shreg    <= '0;
                error    <= 1'b0;
                len_q    <= load_len;
            end else if (state_q == LOAD) begin
                if (ram_we) word_cnt <= word_cnt + ADDR_BITS'(1);
                if (color_ready) begin
                    to_cnt <= '0;
                    shreg  <= shreg_next;
                    if (word_done) begin
                        nit_cnt   <= '0;
                        ram_we    <= 1'b1;
                        ram_wdata <= shreg_next;
                        ram_waddr <= wc_now;
                    end else begin
                        nit_cnt <= nit_cnt + NIT_W'(1);
                    end
                end else if (timeout_hit) begin
                    // abandon the partial word; nothing gets written
                    error   <= 1'b1;
                    nit_cnt <= '0;
                    shreg   <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/program_load_sequencer.md
PROGRAM_LOAD_SEQUENCER -- requirements
Module: program_load_sequencer

Interface
REQ-001 Parameter: WORD_BITS, 12, program word width.
REQ-002 Parameter: ADDR_BITS, 8, RAM address width.
REQ-003 Parameter: NITS_PER_WORD, 6, 2-bit colors per word.
REQ-004 Parameter: TIMEOUT, 1000, max idle cycles between colors during load.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse, begin cartridge load.
REQ-008 load_len  in  ADDR_BITS  words to load; 0 = 2^ADDR_BITS; sampled on accepted start.
REQ-009 color_ready  in  1  one-cycle strobe, color valid.
REQ-010 color  in  2  nit from cartridge.
REQ-011 cpu_req  in  1  CPU fetch request.
REQ-012 cpu_addr  in  ADDR_BITS  CPU fetch address.
REQ-013 cpu_grant  out  1  fetch accepted this cycle.
REQ-014 ram_we  out  1  RAM write enable.
REQ-015 ram_waddr  out  ADDR_BITS  RAM write address.
REQ-016 ram_wdata  out  WORD_BITS  RAM write data.
REQ-017 ram_raddr  out  ADDR_BITS  RAM read address.
REQ-018 loading  out  1  high in LOAD state.
REQ-019 done  out  1  high in RUN state.
REQ-020 error  out  1  sticky timeout flag.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, RUN; encoding free.
REQ-022 IDLE->LOAD on start; word counter, nit counter, timeout counter cleared, error cleared, load_len latched.
REQ-023 LOAD: each color_ready SHALL shift: shreg <= {shreg[WORD_BITS-3:0], color}; nit counter +1; first nit ends in MSBs.
REQ-024 On the color_ready completing nit NITS_PER_WORD, next cycle SHALL assert ram_we for exactly one cycle with ram_wdata = completed word, ram_waddr = word counter; nit counter SHALL return to 0 in that same completion cycle.
REQ-025 Word counter SHALL increment in the ram_we cycle; wraps modulo 2^ADDR_BITS.
REQ-026 color_ready in the ram_we cycle SHALL be accepted as nit 1 of the next word; no nit lost.
REQ-027 When the ram_we cycle writes word index load_len-1 (or 2^ADDR_BITS-1 for load_len=0), FSM SHALL enter RUN the following cycle; color_ready in RUN ignored.
REQ-028 Timeout counter SHALL clear on every color_ready and increment each LOAD cycle otherwise; on reaching TIMEOUT: error<=1, FSM->IDLE, partial word discarded, no write.
REQ-029 start during LOAD SHALL be ignored; start in RUN or IDLE SHALL begin a new load (RUN->LOAD).
REQ-030 cpu_grant SHALL equal cpu_req AND state==RUN (combinational); never high in IDLE/LOAD.
REQ-031 ram_raddr SHALL equal cpu_addr in RUN, 0 otherwise.
REQ-032 ram_we SHALL never assert outside LOAD; loader and CPU never both own RAM.
REQ-033 loading, done decoded from registered state; error registered, cleared only by reset or accepted start.

Reset
REQ-034 reset SHALL override all inputs, including mid-load: state IDLE, ram_we 0, ram_waddr 0, ram_wdata 0, counters 0, shreg 0, error 0, loading 0, done 0, cpu_grant 0.
REQ-035 Words already written before reset SHALL not be rewritten; RAM content unaffected.

Verification
REQ-036 start, load_len=2, 12 colors 0,1,2,3,0,1,2,3,0,1,2,3 back-to-back -> ram_we at addr 0 data 0x1B1, addr 1 data 0xB1B; done high after second write.
REQ-037 color_ready coinciding with ram_we cycle -> counted as nit 1 of next word; word contents exact.
REQ-038 start, load_len=1, 3 colors then silence TIMEOUT cycles -> error=1, state IDLE, no ram_we.
REQ-039 cpu_req=1 cpu_addr=0x05 during LOAD -> cpu_grant=0, ram_raddr=0; in RUN -> cpu_grant=1, ram_raddr=0x05.
REQ-040 reset asserted after 4 nits of word 3 -> all outputs at reset values next cycle; new start reloads from addr 0.
REQ-041 load_len=0 -> 256 writes, ram_waddr 0..255, then done; start during LOAD ignored.
